// File: rtl/jtag_shift_master.sv
// jtag_shift_master
//   Host-side JTAG initiator. Walks the TAP to Shift-DR, shifts one WIDTH-bit
//   word LSB first into the user data register, and returns the captured TDO word.
//
//   Optional feature macro: JTAG_MASTER_IRSCAN_EN
//     When defined, each transaction first loads USER_IR with an IR scan.
//
//   Ports
//     CLK, nRST      clock, asynchronous active-low reset
//     req_enq__ENA   request strobe (only while req_enq__RDY)
//     req_enq_v      word to shift into the DR
//     req_enq__RDY   idle in Run-Test/Idle, accepting a request
//     rsp_enq__ENA   response strobe, 1 CLK
//     rsp_enq_v      captured TDO word
//     rsp_enq__RDY   consumer can accept a response
//     TCK/TMS/TDI    JTAG outputs to the TAP
//     TDO            JTAG data from the TAP
module jtag_shift_master #(
  parameter int unsigned         WIDTH    = 32,
  parameter int unsigned         TCK_DIV  = 2,
  parameter int unsigned         IR_WIDTH = 6,
  parameter logic [IR_WIDTH-1:0] USER_IR  = 6'h02
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req_enq__ENA,
  input  logic [WIDTH-1:0] req_enq_v,
  output logic             req_enq__RDY,
  output logic             rsp_enq__ENA,
  output logic [WIDTH-1:0] rsp_enq_v,
  input  logic             rsp_enq__RDY,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO
);

  localparam int unsigned CNT_SPAN = ((WIDTH > IR_WIDTH) ? WIDTH : IR_WIDTH) + 6;
  localparam int unsigned CW       = $clog2(CNT_SPAN);
  localparam int unsigned DW       = $clog2(TCK_DIV) + 1;

  localparam logic [DW-1:0] DIV_RELOAD = DW'(TCK_DIV - 1);
  localparam logic [CW-1:0] INIT_LAST  = CW'(5);
  localparam logic [CW-1:0] HDR_LAST   = CW'(2);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TRL_LAST   = CW'(1);
`ifdef JTAG_MASTER_IRSCAN_EN
  localparam logic [CW-1:0] IR_SH_FIRST = CW'(4);
  localparam logic [CW-1:0] IR_SH_LAST  = CW'(IR_WIDTH + 3);
  localparam logic [CW-1:0] IR_LAST     = CW'(IR_WIDTH + 5);
`endif

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
`ifdef JTAG_MASTER_IRSCAN_EN
    ST_IR,
`endif
    ST_DR_HDR,
    ST_SHIFT,
    ST_DR_TRL,
    ST_RESP
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [DW-1:0]    r_div, w_div_nx;
  logic             r_tck, w_tck_nx;
  logic             r_tms, w_tms_nx;
  logic             r_tdi, w_tdi_nx;
  logic [WIDTH-1:0] r_sreg, w_sreg_nx;

  logic w_active;
  logic w_rise;
  logic w_end;
  logic w_start;
  logic w_cell_tms;
  logic w_cell_tdi;

`ifdef JTAG_MASTER_IRSCAN_EN
  logic [CW-1:0]       w_ir_idx;
  logic [IR_WIDTH-1:0] w_ir_bits;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^USER_IR;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // Reset leaves cell 0 of INIT already started (TMS=1, TCK low).
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_div   <= DIV_RELOAD;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_div   <= w_div_nx;
      r_tck   <= w_tck_nx;
      r_tms   <= w_tms_nx;
      r_tdi   <= w_tdi_nx;
      r_sreg  <= w_sreg_nx;
    end
  end

  always_comb begin
    w_active   = (r_state != ST_IDLE) && (r_state != ST_RESP);
    w_rise     = w_active && !r_tck && (r_div == '0);
    w_end      = w_active &&  r_tck && (r_div == '0);

    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_div_nx   = r_div;
    w_tck_nx   = r_tck;
    w_tms_nx   = r_tms;
    w_tdi_nx   = r_tdi;
    w_sreg_nx  = r_sreg;
    w_start    = 1'b0;
    w_cell_tms = 1'b0;
    w_cell_tdi = 1'b0;
`ifdef JTAG_MASTER_IRSCAN_EN
    w_ir_idx   = '0;
    w_ir_bits  = '0;
`endif

    // Half-period divider and TCK rise; TDO is sampled on the rising CLK.
    if (w_active && (r_div != '0)) begin
      w_div_nx = r_div - 1'b1;
    end
    if (w_rise) begin
      w_tck_nx = 1'b1;
      w_div_nx = DIV_RELOAD;
      if (r_state == ST_SHIFT) begin
        w_sreg_nx = {TDO, r_sreg[WIDTH-1:1]};
      end
    end
    if (w_end) begin
      w_tck_nx = 1'b0;
      w_tdi_nx = 1'b0;
    end

    // Phase sequencing: each scan state runs a fixed number of cells.
    case (r_state)
      ST_INIT: begin
        if (w_end) begin
          if (r_cnt == INIT_LAST) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
            w_start  = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (req_enq__ENA) begin
          w_sreg_nx = req_enq_v;
          w_cnt_nx  = '0;
          w_start   = 1'b1;
`ifdef JTAG_MASTER_IRSCAN_EN
          w_state_nx = ST_IR;
`else
          w_state_nx = ST_DR_HDR;
`endif
        end
      end
`ifdef JTAG_MASTER_IRSCAN_EN
      ST_IR: begin
        if (w_end) begin
          w_start = 1'b1;
          if (r_cnt == IR_LAST) begin
            w_state_nx = ST_DR_HDR;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
`endif
      ST_DR_HDR: begin
        if (w_end) begin
          w_start = 1'b1;
          if (r_cnt == HDR_LAST) begin
            w_state_nx = ST_SHIFT;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (w_end) begin
          w_start = 1'b1;
          if (r_cnt == SHIFT_LAST) begin
            w_state_nx = ST_DR_TRL;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_DR_TRL: begin
        if (w_end) begin
          if (r_cnt == TRL_LAST) begin
            w_state_nx = ST_RESP;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
            w_start  = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_enq__RDY) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_INIT;
        w_cnt_nx   = '0;
      end
    endcase

    // TMS/TDI for the cell being started, from the phase and cell index it starts in.
    case (w_state_nx)
      ST_INIT: begin
        w_cell_tms = (w_cnt_nx != INIT_LAST);
      end
`ifdef JTAG_MASTER_IRSCAN_EN
      ST_IR: begin
        if (w_cnt_nx < IR_SH_FIRST) begin
          w_cell_tms = (w_cnt_nx < CW'(2));
        end else if (w_cnt_nx <= IR_SH_LAST) begin
          w_ir_idx   = w_cnt_nx - IR_SH_FIRST;
          w_ir_bits  = USER_IR >> w_ir_idx;
          w_cell_tms = (w_cnt_nx == IR_SH_LAST);
          w_cell_tdi = w_ir_bits[0];
        end else begin
          w_cell_tms = (w_cnt_nx != IR_LAST);
        end
      end
`endif
      ST_DR_HDR: begin
        w_cell_tms = (w_cnt_nx == '0);
      end
      ST_SHIFT: begin
        w_cell_tms = (w_cnt_nx == SHIFT_LAST);
        w_cell_tdi = r_sreg[0];
      end
      ST_DR_TRL: begin
        w_cell_tms = (w_cnt_nx == '0);
      end
      default: begin
        w_cell_tms = 1'b0;
        w_cell_tdi = 1'b0;
      end
    endcase

    if (w_start) begin
      w_tck_nx = 1'b0;
      w_div_nx = DIV_RELOAD;
      w_tms_nx = w_cell_tms;
      w_tdi_nx = w_cell_tdi;
    end
  end

  assign TCK          = r_tck;
  assign TMS          = r_tms;
  assign TDI          = r_tdi;
  assign rsp_enq_v    = r_sreg;
  assign req_enq__RDY = (r_state == ST_IDLE);
  assign rsp_enq__ENA = (r_state == ST_RESP) && rsp_enq__RDY;

endmodule
